// File: rtl/kronos_bus_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master between the
// Kronos instruction and data ports, with a WAIT-state response timeout.
module kronos_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic                    instr_ack,
  output logic [DATA_WIDTH-1:0]   instr_data,
  input  logic                    data_req,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wr_data,
  input  logic [DATA_WIDTH/8-1:0] data_mask,
  input  logic                    data_wr_en,
  output logic                    data_ack,
  output logic [DATA_WIDTH-1:0]   data_rd_data,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [ADDR_WIDTH-1:0]   wb_addr,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack,
  output logic                    bus_error,
  output logic [1:0]              fsm_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic             last_grant;  // 1 = data port; also names the current owner
  logic [CNT_W-1:0] wait_cnt;
  logic             pick_data;
  logic             timeout_hit;
  logic             resp_go;
  logic [DATA_WIDTH-1:0] resp_data;

  assign fsm_state = state;

  // On a tie the port that did not win last time gets the bus.
  assign pick_data   = data_req && (!instr_req || !last_grant);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
  assign resp_go     = ((state == ISSUE) && wb_ack) ||
                       ((state == WAIT) && (wb_ack || timeout_hit));
  assign resp_data   = wb_ack ? wb_data_i : '0;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      instr_ack    <= 1'b0;
      instr_data   <= '0;
      data_ack     <= 1'b0;
      data_rd_data <= '0;
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_sel       <= '0;
      wb_addr      <= '0;
      wb_data_o    <= '0;
      bus_error    <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_req || data_req) begin
            last_grant <= pick_data;
            wb_cyc     <= 1'b1;
            wb_stb     <= 1'b1;
            if (pick_data) begin
              wb_we     <= data_wr_en;
              wb_sel    <= data_mask;
              wb_addr   <= data_addr;
              wb_data_o <= data_wr_data;
            end else begin
              wb_we     <= 1'b0;
              wb_sel    <= '1;
              wb_addr   <= instr_addr;
              wb_data_o <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (resp_go) begin
            // A slave ack in the timeout cycle wins: bus_error only without ack.
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            bus_error <= !wb_ack;
            if (last_grant) begin
              data_ack     <= 1'b1;
              data_rd_data <= resp_data;
            end else begin
              instr_ack  <= 1'b1;
              instr_data <= resp_data;
            end
            state <= RESP;
          end else begin
            wb_stb <= 1'b0;
            if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            state <= WAIT;
          end
        end
        RESP: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/kronos_bus_arbiter.md
Name: kronos_bus_arbiter

Overview:
Shares a single pipelined Wishbone master port between the Kronos core's instruction port and data port when only one memory is available. Arbitrates round-robin and registers the selected request onto the bus. Captures the slave response and returns a one-cycle ack to the granted requester. A response timeout prevents the core from hanging on an unmapped slave.

Parameters:
ADDR_WIDTH, 32, address width of both requester ports and the bus
DATA_WIDTH, 32, data width; byte-select width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, WAIT cycles before a forced error response; 0 disables the timeout

Ports:
sys_clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
instr_req  in  1  instruction fetch request, held until instr_ack
instr_addr  in  ADDR_WIDTH  fetch address
instr_ack  out  1  one-cycle fetch completion
instr_data  out  DATA_WIDTH  fetch data, valid with instr_ack
data_req  in  1  data request, held until data_ack
data_addr  in  ADDR_WIDTH  data address
data_wr_data  in  DATA_WIDTH  write data
data_mask  in  DATA_WIDTH/8  byte enables
data_wr_en  in  1  1 = write, 0 = read
data_ack  out  1  one-cycle data completion
data_rd_data  out  DATA_WIDTH  read data, valid with data_ack
wb_cyc  out  1  bus cycle active
wb_stb  out  1  bus strobe
wb_we  out  1  bus write enable
wb_sel  out  DATA_WIDTH/8  bus byte selects
wb_addr  out  ADDR_WIDTH  bus address
wb_data_o  out  DATA_WIDTH  bus write data
wb_data_i  in  DATA_WIDTH  bus read data
wb_ack  in  1  bus acknowledge
bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0. State goes to IDLE, timeout counter to 0, last_grant to DATA, so instr wins the first tie.
- A reset asserted mid-transaction drops wb_cyc/wb_stb immediately. No ack is issued for the aborted request.
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample instr_req and data_req.
  - Only one request high: grant it.
  - Both high: grant the port that is not last_grant, then update last_grant.
  - Neither high: stay in IDLE.
  - On grant, register addr, write data, sel and we onto the wb_* outputs, then go to ISSUE.
  - Instruction grants always drive wb_we=0 and wb_sel=all ones.
- ISSUE (exactly 1 cycle):
  - Drive wb_cyc=1 and wb_stb=1.
  - wb_ack high in this cycle: capture wb_data_i and go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - Drive wb_cyc=1, wb_stb=0. The timeout counter increments each cycle.
  - wb_ack high: capture wb_data_i and go to RESP.
  - TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES: captured data becomes 0, bus_error=1 in the RESP cycle, go to RESP.
  - wb_ack has priority over timeout in the same cycle.
- RESP (exactly 1 cycle):
  - wb_cyc=0. The granted port's ack=1 with the captured data; the other ack stays 0. Counter clears.
  - Next state is IDLE.
  - For writes, data_rd_data carries the captured wb_data_i and is don't-care to the core.
- Latency: request sampled in IDLE at cycle N, wb_stb at N+1, ack to requester at N+2 at the earliest. Back-to-back throughput is one transaction per 3 cycles minimum.
- instr_data/data_rd_data hold their last value outside ack cycles.
- wb_ack outside ISSUE/WAIT is ignored.
- A request that drops while granted still completes and still receives its ack pulse. Requesters must not drop a request before ack.
- Data fields are registered only in IDLE. Input changes after grant do not affect the bus.

Test Plan:
- Single instr fetch at instr_addr=0x0000_0100, slave acks 1 cycle after stb with 0x0000_0013 -> wb_we=0, wb_sel=0xF, wb_addr=0x100; instr_ack at N+3 with instr_data=0x13; data_ack stays 0.
- Data write to addr 0x8000_0004, data 0xCAFE_F00D, mask 0x3, slave acks in the ISSUE cycle -> wb_we=1, wb_sel=0x3, wb_data_o=0xCAFEF00D; data_ack at N+2; bus_error 0.
- Both requests held continuously from reset -> grants alternate instr, data, instr, data. No port is granted twice in a row.
- Slave never acks, TIMEOUT_CYCLES=4 -> after 4 WAIT cycles, data_ack=1 with data_rd_data=0 and bus_error=1 in the same cycle, then IDLE.
- Async rst_n low during WAIT -> wb_cyc/wb_stb drop in the same cycle, no ack. After release, a pending data-only request is granted again from IDLE.
- wb_ack and timeout coincide in the same WAIT cycle -> normal response with slave data, bus_error stays 0.
